// File: rtl/fwd_hazard_scoreboard_pkg.sv
// Shared constants for the operand bypass / hazard unit.
// Select encoding: 0 picks the register file, k picks bypass stage k (1 = MEM).
package fwd_hazard_scoreboard_pkg;

  localparam int AW_DEF      = 5;
  localparam int FWD_RF      = 0;
  localparam int FWD_STG_MEM = 1;

endpackage

// File: rtl/fwd_src_match.sv
// Priority match of one source operand against all bypass stages.
// Produces the forward select and this operand's hazard bit.
module fwd_src_match
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STG = 2,
  parameter int AW      = AW_DEF,
  parameter int SEL_W   = $clog2(NUM_STG + 1)
) (
  input  logic                  src_valid,
  input  logic [AW-1:0]         src_addr,
  input  logic                  src_busy,
  input  logic [NUM_STG-1:0]    stg_regwrite,
  input  logic [NUM_STG*AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]    stg_ready,
  output logic [SEL_W-1:0]      sel,
  output logic                  hazard
);

  logic hit;
  logic hit_ready;

  always_comb begin
    sel       = SEL_W'(FWD_RF);
    hit       = 1'b0;
    hit_ready = 1'b1;
    // Walk from the farthest stage inward so the nearest match overwrites.
    for (int k = NUM_STG; k >= FWD_STG_MEM; k--) begin
      if (src_valid && stg_regwrite[k-1] &&
          (stg_rd[(k-1)*AW +: AW] != '0) &&
          (stg_rd[(k-1)*AW +: AW] == src_addr)) begin
        sel       = SEL_W'(k);
        hit       = 1'b1;
        hit_ready = stg_ready[k-1];
      end
    end
    hazard = hit ? !hit_ready : (src_valid && src_busy);
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Operand bypass selects, load-use / multi-cycle stall, and stall counter.
// Per-register down-counters track multi-cycle producers outside the bypass window.
module fwd_hazard_scoreboard
  import fwd_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 2,
  parameter int AW      = AW_DEF,
  parameter int MAX_LAT = 8,
  parameter int SEL_W   = $clog2(NUM_STG + 1),
  parameter int CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*AW-1:0]         src_addr,
  input  logic [NUM_STG-1:0]            stg_regwrite,
  input  logic [NUM_STG*AW-1:0]         stg_rd,
  input  logic [NUM_STG-1:0]            stg_ready,
  input  logic                          mc_issue,
  input  logic [AW-1:0]                 mc_rd,
  input  logic [$clog2(MAX_LAT+1)-1:0]  mc_lat,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall,
  output logic [2**AW-1:0]              busy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int NREG  = 2**AW;
  localparam int LAT_W = $clog2(MAX_LAT + 1);

  logic [NUM_SRC-1:0] hazard;
  logic [LAT_W-1:0]   lat_eff;
  logic               issue_en;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .NUM_STG (NUM_STG),
      .AW      (AW),
      .SEL_W   (SEL_W)
    ) u_match (
      .src_valid    (src_valid[i]),
      .src_addr     (src_addr[i*AW +: AW]),
      .src_busy     (busy[src_addr[i*AW +: AW]]),
      .stg_regwrite (stg_regwrite),
      .stg_rd       (stg_rd),
      .stg_ready    (stg_ready),
      .sel          (fwd_sel[i*SEL_W +: SEL_W]),
      .hazard       (hazard[i])
    );
  end

  assign stall    = |hazard;
  assign issue_en = mc_issue && !stall && (mc_rd != '0);

  always_comb begin
    lat_eff = mc_lat;
    if (mc_lat == '0)
      lat_eff = LAT_W'(1);
    else if (mc_lat > LAT_W'(MAX_LAT))
      lat_eff = LAT_W'(MAX_LAT);
  end

  // x0 is hardwired idle; every other register owns a private down-counter.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign busy[r] = 1'b0;
    end else begin : g_cnt
      logic [LAT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_q <= '0;
        else if (flush)
          cnt_q <= '0;
        else if (issue_en && (mc_rd == AW'(r)))
          cnt_q <= lat_eff;
        else if (cnt_q != '0)
          cnt_q <= cnt_q - LAT_W'(1);
      end

      assign busy[r] = (cnt_q != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_fwd_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [1:0]  src_valid;
  logic [9:0]  src_addr;
  logic [1:0]  stg_regwrite;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_ready;
  logic        mc_issue;
  logic [4:0]  mc_rd;
  logic [3:0]  mc_lat;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [31:0] busy;
  logic [31:0] stall_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  bit          cmp_en = 0;

  int          m_cnt [32];
  logic [31:0] m_scnt;

  fwd_hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_addr     (src_addr),
    .stg_regwrite (stg_regwrite),
    .stg_rd       (stg_rd),
    .stg_ready    (stg_ready),
    .mc_issue     (mc_issue),
    .mc_rd        (mc_rd),
    .mc_lat       (mc_lat),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .stall        (stall),
    .busy         (busy),
    .stall_cnt    (stall_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---- behavioural model ----
  function automatic int exp_sel(int i);
    int a;
    if (!src_valid[i]) return 0;
    a = int'(src_addr[i*5 +: 5]);
    if (a == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (stg_regwrite[k-1] && int'(stg_rd[(k-1)*5 +: 5]) == a) return k;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit h = 0;
    for (int i = 0; i < 2; i++) begin
      int s = exp_sel(i);
      if (s != 0 && !stg_ready[s-1]) h = 1;
      if (s == 0 && src_valid[i] && m_cnt[int'(src_addr[i*5 +: 5])] > 0) h = 1;
    end
    return h;
  endfunction

  function automatic logic [31:0] exp_busy();
    logic [31:0] b = '0;
    for (int r = 0; r < 32; r++) b[r] = (m_cnt[r] > 0);
    return b;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] <= 0;
      m_scnt <= '0;
    end else begin
      if (exp_stall() && !flush && m_scnt != 32'hFFFF_FFFF) m_scnt <= m_scnt + 1;
      for (int r = 0; r < 32; r++) begin
        if (flush) m_cnt[r] <= 0;
        else if (m_cnt[r] > 0) m_cnt[r] <= m_cnt[r] - 1;
      end
      if (!flush && mc_issue && !exp_stall() && mc_rd != 0)
        m_cnt[mc_rd] <= (mc_lat == 0) ? 1 : ((mc_lat > 8) ? 8 : int'(mc_lat));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_fwd_sel0", 64'(fwd_sel[1:0]), 64'(exp_sel(0)));
      check("m_fwd_sel1", 64'(fwd_sel[3:2]), 64'(exp_sel(1)));
      check("m_stall", 64'(stall), 64'(exp_stall()));
      check("m_busy", 64'(busy), 64'(exp_busy()));
      check("m_stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    end
  end

  // ---- stimulus helpers ----
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic clr();
    src_valid = '0; src_addr = '0; stg_regwrite = '0; stg_rd = '0;
    stg_ready = '1; mc_issue = 0; mc_rd = '0; mc_lat = '0; flush = 0;
  endtask

  task automatic set_stg(input int k, input bit we, input logic [4:0] rd, input bit rdy);
    stg_regwrite[k-1] = we;
    stg_rd[(k-1)*5 +: 5] = rd;
    stg_ready[k-1] = rdy;
  endtask

  task automatic set_src(input int i, input bit v, input logic [4:0] a);
    src_valid[i] = v;
    src_addr[i*5 +: 5] = a;
  endtask

  task automatic mc(input bit iss, input logic [4:0] rd, input logic [3:0] lat);
    mc_issue = iss; mc_rd = rd; mc_lat = lat;
  endtask

  initial begin
    clr();
    rst = 1;
    cmp_en = 1;
    smp();
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    nxt();
    rst = 0;

    // plain forwarding, nearest stage wins
    set_stg(1, 1, 5'd5, 1); set_stg(2, 1, 5'd5, 1); set_src(0, 1, 5'd5);
    smp();
    check("fwd_nearest", 64'(fwd_sel[1:0]), 64'd1);
    check("fwd_nostall", 64'(stall), 64'd0);
    nxt();
    set_stg(1, 0, 5'd5, 1); set_src(0, 0, 5'd0); set_src(1, 1, 5'd5);
    smp();
    check("fwd_wb", 64'(fwd_sel[3:2]), 64'd2);

    // x0 never forwards
    nxt(); clr();
    set_stg(1, 1, 5'd0, 1); set_src(0, 1, 5'd0);
    smp();
    check("x0_sel", 64'(fwd_sel[1:0]), 64'd0);
    check("x0_stall", 64'(stall), 64'd0);

    // load-use
    nxt(); clr();
    set_stg(1, 1, 5'd7, 0); set_src(1, 1, 5'd7);
    smp();
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_cnt0", 64'(stall_cnt), 64'd0);
    nxt();
    set_stg(1, 1, 5'd7, 1);
    smp();
    check("lu_release", 64'(stall), 64'd0);
    check("lu_sel", 64'(fwd_sel[3:2]), 64'd1);
    check("lu_cnt1", 64'(stall_cnt), 64'd1);

    // multi-cycle countdown
    nxt(); clr();
    mc(1, 5'd9, 4'd3);
    nxt();
    mc(0, 5'd0, 4'd0); set_src(0, 1, 5'd9);
    for (int j = 0; j < 4; j++) begin
      smp();
      check("mc_stall", 64'(stall), 64'(j < 3));
      check("mc_busy9", 64'(busy[9]), 64'(j < 3));
      if (j < 3) nxt();
    end
    check("mc_cnt", 64'(stall_cnt), 64'd4);

    // WAW overwrite
    nxt(); clr();
    mc(1, 5'd4, 4'd5);
    nxt();
    mc(0, 5'd0, 4'd0);
    smp();
    check("waw_busy_a", 64'(busy[4]), 64'd1);
    nxt();
    mc(1, 5'd4, 4'd2);
    nxt();
    mc(0, 5'd0, 4'd0);
    smp();
    check("waw_busy_b", 64'(busy[4]), 64'd1);
    nxt(); smp();
    check("waw_busy_c", 64'(busy[4]), 64'd1);
    nxt(); smp();
    check("waw_clear", 64'(busy[4]), 64'd0);

    // latency 0 behaves as 1
    nxt();
    mc(1, 5'd4, 4'd0);
    nxt();
    mc(0, 5'd0, 4'd0);
    smp();
    check("lat0_busy", 64'(busy[4]), 64'd1);
    nxt(); smp();
    check("lat0_clear", 64'(busy[4]), 64'd0);

    // flush beats pending entries and a same-cycle issue
    nxt();
    mc(1, 5'd3, 4'd6);
    nxt();
    mc(1, 5'd6, 4'd6);
    nxt();
    mc(1, 5'd10, 4'd5); flush = 1;
    smp();
    check("fl_pending", 64'(busy), 64'h0000_0048);
    nxt();
    mc(0, 5'd0, 4'd0); flush = 0;
    smp();
    check("fl_cleared", 64'(busy), 64'h0);

    // issue while stalled is dropped
    nxt();
    set_stg(1, 1, 5'd7, 0); set_src(0, 1, 5'd7); mc(1, 5'd11, 4'd4);
    smp();
    check("gate_stall", 64'(stall), 64'd1);
    nxt(); clr();
    smp();
    check("gate_busy", 64'(busy), 64'h0);
    check("gate_cnt", 64'(stall_cnt), 64'd5);

    // async reset mid-operation
    set_stg(1, 1, 5'd7, 0); set_src(0, 1, 5'd7);
    repeat (5) nxt();
    clr();
    mc(1, 5'd12, 4'd4);
    nxt();
    mc(0, 5'd0, 4'd0); set_src(0, 1, 5'd12);
    smp();
    check("ar_pre_busy", 64'(busy), 64'h0000_1000);
    check("ar_pre_cnt", 64'(stall_cnt), 64'd10);
    rst = 1;
    #1;
    check("ar_busy", 64'(busy), 64'h0);
    check("ar_cnt", 64'(stall_cnt), 64'h0);
    check("ar_stall", 64'(stall), 64'h0);
    #1 rst = 0;
    nxt(); smp();
    check("ar_after", 64'(stall_cnt), 64'h0);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      nxt();
      src_valid    = 2'($urandom);
      src_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_regwrite = 2'($urandom);
      stg_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      stg_ready    = {($urandom % 4) != 0, ($urandom % 4) != 0};
      mc_issue     = ($urandom % 3) == 0;
      mc_rd        = 5'($urandom_range(0, 7));
      mc_lat       = 4'($urandom_range(0, 15));
      flush        = ($urandom % 40) == 0;
      if (c % 700 == 699) begin
        #1 rst = 1;
        #1 rst = 0;
      end
    end

    nxt(); clr();
    smp();
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
